// File: rtl/rand_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rand_arbiter_pkg : shared FSM encoding, random width and limit-to-mask helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package rand_arbiter_pkg;

  localparam int RND_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Smallest all-ones mask covering lim-1; lim=0 selects the full range.
  function automatic logic [RND_W-1:0] mask_for_limit(input logic [RND_W-1:0] lim);
    logic [RND_W-1:0] m;
    if (lim == '0) begin
      m = '1;
    end else begin
      m = lim - RND_W'(1);
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rand_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first set request at or after ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand_idx;

  // Scan from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    idx      = '0;
    valid    = 1'b0;
    cand_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand_idx = IDX_W'((int'(ptr) + i) % N);
      if (req[cand_idx]) begin
        idx   = cand_idx;
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rand_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rand_arbiter : round-robin sharing of one random source with range reduction
// Revision: 1.0
// ---------------------------------------------------------------------------
module rand_arbiter
  import rand_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_TRIES = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_h,
  input  logic [RND_W-1:0]         rnd,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*RND_W-1:0] limit,
  output logic [NUM_REQ-1:0]       ack,
  output logic [RND_W-1:0]         data,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TRY_W = 3;

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [RND_W-1:0]   lim, lim_nxt;
  logic [RND_W-1:0]   mask, mask_nxt;
  logic [RND_W-1:0]   cand, data_nxt;
  logic [TRY_W-1:0]   tries, tries_nxt;
  logic [NUM_REQ-1:0] ack_nxt, owner_hot;
  logic               busy_nxt;
  logic [RND_W-1:0]   lim_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lim
    assign lim_arr[g] = limit[RND_W*g +: RND_W];
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign cand      = rnd & mask;
  assign owner_hot = NUM_REQ'(1) << owner;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    lim_nxt    = lim;
    mask_nxt   = mask;
    tries_nxt  = tries;
    rr_ptr_nxt = rr_ptr;
    ack_nxt    = '0;
    data_nxt   = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nxt = pick_idx;
          lim_nxt   = lim_arr[pick_idx];
          mask_nxt  = mask_for_limit(lim_arr[pick_idx]);
          tries_nxt = '0;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (!req[owner]) begin
          state_nxt = IDLE;
        end else if (lim == '0 || cand < lim) begin
          data_nxt  = cand;
          ack_nxt   = owner_hot;
          state_nxt = DONE;
        end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
          // cand <= 2*lim-1 by construction of the mask, so this lands below lim.
          data_nxt  = cand - lim;
          ack_nxt   = owner_hot;
          state_nxt = DONE;
        end else begin
          tries_nxt = tries + TRY_W'(1);
        end
      end
      DONE: begin
        rr_ptr_nxt = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state  <= IDLE;
      owner  <= '0;
      lim    <= '0;
      mask   <= '0;
      tries  <= '0;
      rr_ptr <= '0;
      ack    <= '0;
      data   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      lim    <= lim_nxt;
      mask   <= mask_nxt;
      tries  <= tries_nxt;
      rr_ptr <= rr_ptr_nxt;
      ack    <= ack_nxt;
      data   <= data_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rand_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rand_arbiter : randomized self-checking bench against a transaction model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rand_arbiter;

  localparam int N  = 4;
  localparam int MT = 4;

  logic            Clk = 1'b0;
  logic            Reset_h;
  logic [9:0]      rnd;
  logic [N-1:0]    req;
  logic [N*10-1:0] limit;
  logic [N-1:0]    ack;
  logic [9:0]      data;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;
  int exp_ptr     = 0;

  always #5 Clk = ~Clk;

  rand_arbiter #(
    .NUM_REQ   (N),
    .MAX_TRIES (MT)
  ) dut (
    .Clk     (Clk),
    .Reset_h (Reset_h),
    .rnd     (rnd),
    .req     (req),
    .limit   (limit),
    .ack     (ack),
    .data    (data),
    .busy    (busy)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int ref_mask(input int lim);
    if (lim == 0) return 1023;
    for (int k = 0; k <= 10; k++)
      if ((1 << k) - 1 >= lim - 1) return (1 << k) - 1;
    return 1023;
  endfunction

  function automatic int ref_winner(input logic [N-1:0] pat, input int ptr);
    for (int i = 0; i < N; i++)
      if (pat[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Expected value and number of draw cycles for one grant.
  task automatic ref_draw(input int lim, input int vals[8], output int val, output int n);
    int  m;
    bit  done;
    m = ref_mask(lim);
    val = 0; n = MT; done = 0;
    for (int t = 0; t < MT; t++) begin
      if (!done) begin
        int c;
        c = vals[t] & m;
        if (lim == 0 || c < lim) begin
          val = c; n = t + 1; done = 1;
        end else if (t == MT - 1) begin
          val = c - lim; n = MT; done = 1;
        end
      end
    end
  endtask

  task automatic apply_reset();
    Reset_h = 1'b1; req = '0; limit = '0; rnd = '0;
    tick();
    Reset_h = 1'b0;
    exp_ptr = 0;
  endtask

  // Single-requester transaction with a scripted rnd sequence.
  task automatic do_txn(input int idx, input int lim, input int vals[8], input string name);
    int exp_d, exp_n, edges;
    bit seen;
    ref_draw(lim, vals, exp_d, exp_n);
    req = '0; req[idx] = 1'b1;
    limit[idx*10 +: 10] = 10'(lim);
    rnd = 10'($urandom);
    tick();
    edges = 1; seen = 0;
    limit[idx*10 +: 10] = 10'($urandom);
    for (int t = 0; t < MT + 2 && !seen; t++) begin
      rnd = 10'(vals[t]);
      tick();
      edges++;
      vectors++;
      if (ack != 0) seen = 1'b1;
      else if (busy !== 1'b1 || data !== 10'd0) begin
        miscompares++;
        $display("FAIL %s draw_state: busy=%0b data=%0d required busy=1 data=0", name, busy, data);
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s ack_timeout: no ack after %0d edges, required at %0d", name, edges, exp_n + 1);
    end else begin
      vectors++;
      if (ack !== N'(1 << idx)) begin
        miscompares++;
        $display("FAIL %s ack: got %b required %b", name, ack, N'(1 << idx));
      end
      vectors++;
      if (data !== 10'(exp_d)) begin
        miscompares++;
        $display("FAIL %s data: got %0d required %0d (lim %0d)", name, data, exp_d, lim);
      end
      vectors++;
      if (lim != 0 && int'(data) >= lim) begin
        miscompares++;
        $display("FAIL %s range: got %0d required below %0d", name, data, lim);
      end
      vectors++;
      if (edges != exp_n + 1) begin
        miscompares++;
        $display("FAIL %s latency: got %0d edges required %0d", name, edges, exp_n + 1);
      end
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s busy_done: got %0b required 1", name, busy);
      end
      exp_ptr = (idx + 1) % N;
    end
    req[idx] = 1'b0;
    rnd = 10'($urandom);
    tick();
    vectors++;
    if ({ack, data, busy} !== '0) begin
      miscompares++;
      $display("FAIL %s after_done: ack=%b data=%0d busy=%0b required all 0", name, ack, data, busy);
    end
  endtask

  // Hold a request pattern with always-accepting limits and check grant order.
  task automatic run_rr(input logic [N-1:0] pat, input int count, input string name);
    int got, exp_w;
    bit prev_ack;
    logic [9:0] r_app;
    limit = '0; req = pat; got = 0; prev_ack = 0;
    for (int cyc = 0; cyc < count * 6 && got < count; cyc++) begin
      rnd = 10'($urandom);
      r_app = rnd;
      tick();
      vectors++;
      if (ack != 0) begin
        exp_w = ref_winner(pat, exp_ptr);
        if (ack !== N'(1 << exp_w) || data !== r_app || prev_ack) begin
          miscompares++;
          $display("FAIL %s grant%0d: ack=%b data=%0d prev_ack=%0b required ack=%b data=%0d prev_ack=0",
                   name, got, ack, data, prev_ack, N'(1 << exp_w), r_app);
        end
        exp_ptr = (exp_w + 1) % N;
        got++;
      end else if (data !== 10'd0) begin
        miscompares++;
        $display("FAIL %s idle_data: got %0d required 0", name, data);
      end
      prev_ack = (ack != 0);
    end
    vectors++;
    if (got != count) begin
      miscompares++;
      $display("FAIL %s grant_count: got %0d required %0d", name, got, count);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset_h = 1'b1; req = '0; limit = '0; rnd = '0;
    tick();
    tick();
    vectors++;
    if ({ack, data, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset: ack=%b data=%0d busy=%0b required all 0", ack, data, busy);
    end
    Reset_h = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_directed();
    int v[8];
    v = '{37, 0, 0, 0, 0, 0, 0, 0};
    do_txn(0, 100, v, "single");
    v = '{120, 110, 45, 0, 0, 0, 0, 0};
    do_txn(0, 100, v, "reject");
    v = '{120, 127, 101, 110, 0, 0, 0, 0};
    do_txn(0, 100, v, "fallback");
    v = '{1023, 1023, 1023, 1023, 0, 0, 0, 0};
    do_txn(2, 1023, v, "lim1023_fallback");
  endtask

  task automatic test_sweep();
    int v[8];
    for (int lim = 1; lim < 1024; lim++) begin
      for (int k = 0; k < 8; k++) v[k] = int'($urandom_range(1023, 0));
      do_txn(int'($urandom_range(N - 1, 0)), lim, v, "sweep");
    end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) v[k] = int'($urandom_range(1023, 0));
      do_txn(int'($urandom_range(N - 1, 0)), 0, v, "lim0");
      do_txn(int'($urandom_range(N - 1, 0)), 1, v, "lim1");
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    run_rr(4'b1111, 5, "rr_all");
    for (int r = 0; r < 20; r++)
      run_rr(N'($urandom_range((1 << N) - 1, 1)), int'($urandom_range(4, 1)), "rr_rand");
  endtask

  task automatic test_abort();
    int v[8];
    apply_reset();
    v = '{5, 0, 0, 0, 0, 0, 0, 0};
    do_txn(1, 0, v, "abort_setup");
    req = 4'b0100; limit = '0; limit[2*10 +: 10] = 10'd100; rnd = 10'd120;
    tick();
    rnd = 10'd120;
    tick();
    req = '0; rnd = 10'd120;
    tick();
    vectors++;
    if ({ack, busy} !== '0) begin
      miscompares++;
      $display("FAIL abort: ack=%b busy=%0b required 0 0", ack, busy);
    end
    run_rr(4'b0110, 1, "abort_ptr");
  endtask

  task automatic test_reset_mid_draw();
    int v[8];
    apply_reset();
    v = '{5, 0, 0, 0, 0, 0, 0, 0};
    do_txn(1, 0, v, "rstmid_setup");
    req = 4'b0010; limit = '0; limit[1*10 +: 10] = 10'd100; rnd = 10'd120;
    tick();
    rnd = 10'd120;
    tick();
    Reset_h = 1'b1; rnd = 10'd45;
    tick();
    vectors++;
    if ({ack, data, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_draw: ack=%b data=%0d busy=%0b required all 0", ack, data, busy);
    end
    Reset_h = 1'b0; req = '0;
    exp_ptr = 0;
    run_rr(4'b0101, 1, "rstmid_ptr");
  endtask

  task automatic test_held();
    apply_reset();
    run_rr(4'b1010, 3, "held");
  endtask

  initial begin
    Reset_h = 1'b1; req = '0; limit = '0; rnd = '0;
    test_reset();
    test_directed();
    test_sweep();
    test_round_robin();
    test_abort();
    test_reset_mid_draw();
    test_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
